// File: rtl/dds_pkg.sv
// Shared widths, config-slot state encoding and config record for the DDS phase accumulator.
package dds_pkg;

    localparam int DDS_ACC_W = 32;
    localparam int DDS_OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND_IMM  = 2'd1,
        PEND_WRAP = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [DDS_ACC_W-1:0] ftw;
        logic [DDS_ACC_W-1:0] poff;
        logic [DDS_ACC_W-1:0] step;
        logic                 sync;
    } dds_cfg_t;

endpackage

// File: rtl/dds_cfg_slot.sv
// One-deep config holding register with valid/ready handshake; strobes apply either on the
// next enabled edge or on the next enabled edge that carries out of the accumulator.
module dds_cfg_slot
    import dds_pkg::*;
#(
    parameter int ACC_W = DDS_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             carry,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [ACC_W-1:0] cfg_poff,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic             cfg_sync,
    output logic             apply,
    output logic [ACC_W-1:0] slot_ftw,
    output logic [ACC_W-1:0] slot_poff,
    output logic [ACC_W-1:0] slot_step
);

    cfg_state_e       state_reg, state_next;
    logic [ACC_W-1:0] ftw_reg, poff_reg, step_reg;
    logic             accept;

    assign cfg_ready = (state_reg == IDLE) && !rst;
    assign accept    = cfg_valid && cfg_ready;

    // Accept only happens in IDLE, so accept and apply can never coincide.
    always_comb begin
        state_next = state_reg;
        apply      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = cfg_sync ? PEND_WRAP : PEND_IMM;
                end
            end
            PEND_IMM: begin
                if (en) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
            PEND_WRAP: begin
                if (en && carry) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_reg  <= '0;
            poff_reg <= '0;
            step_reg <= '0;
        end else if (accept) begin
            ftw_reg  <= cfg_ftw;
            poff_reg <= cfg_poff;
            step_reg <= cfg_step;
        end
    end

    assign slot_ftw  = ftw_reg;
    assign slot_poff = poff_reg;
    assign slot_step = step_reg;

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: integrates the tuning word, optionally sweeps it, adds the phase
// offset and registers the truncated phase word plus valid and wrap markers.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W = DDS_ACC_W,
    parameter int OUT_W = DDS_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [ACC_W-1:0] cfg_poff,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic             cfg_sync,
    output logic [OUT_W-1:0] phase_out,
    output logic             phase_valid,
    output logic             wrap_pulse
);

    logic [ACC_W-1:0] acc_reg, ftw_reg, poff_reg, step_reg;
    logic             carry_reg;
    logic [OUT_W-1:0] phase_out_reg;
    logic             phase_valid_reg, wrap_pulse_reg;

    logic [ACC_W:0]   sum_next;
    logic [ACC_W-1:0] phase_full;
    logic             apply;
    logic [ACC_W-1:0] slot_ftw, slot_poff, slot_step;

    assign sum_next   = {1'b0, acc_reg} + {1'b0, ftw_reg};
    assign phase_full = acc_reg + poff_reg;

    dds_cfg_slot #(
        .ACC_W(ACC_W)
    ) u_cfg_slot (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .carry     (sum_next[ACC_W]),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_poff  (cfg_poff),
        .cfg_step  (cfg_step),
        .cfg_sync  (cfg_sync),
        .apply     (apply),
        .slot_ftw  (slot_ftw),
        .slot_poff (slot_poff),
        .slot_step (slot_step)
    );

    // The applying edge still integrates with the old ftw and uses the old poff for its sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg         <= '0;
            ftw_reg         <= '0;
            poff_reg        <= '0;
            step_reg        <= '0;
            carry_reg       <= 1'b0;
            phase_out_reg   <= '0;
            phase_valid_reg <= 1'b0;
            wrap_pulse_reg  <= 1'b0;
        end else if (en) begin
            acc_reg         <= sum_next[ACC_W-1:0];
            carry_reg       <= sum_next[ACC_W];
            phase_out_reg   <= phase_full[ACC_W-1 -: OUT_W];
            wrap_pulse_reg  <= carry_reg;
            phase_valid_reg <= 1'b1;
            if (apply) begin
                ftw_reg  <= slot_ftw;
                poff_reg <= slot_poff;
                step_reg <= slot_step;
            end else begin
                ftw_reg  <= ftw_reg + step_reg;
            end
        end else begin
            phase_valid_reg <= 1'b0;
            wrap_pulse_reg  <= 1'b0;
        end
    end

    assign phase_out   = phase_out_reg;
    assign phase_valid = phase_valid_reg;
    assign wrap_pulse  = wrap_pulse_reg;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed, table-driven bench for dds_phase_acc with hand-computed expected samples.
module tb_dds_phase_acc;
    import dds_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_poff;
    logic [31:0] cfg_step;
    logic        cfg_sync;
    logic [15:0] phase_out;
    logic        phase_valid;
    logic        wrap_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          rst;
        bit          en;
        bit          vld;
        dds_cfg_t    cfg;
        logic [15:0] e_phase;
        bit          e_pv;
        bit          e_wrap;
        bit          e_rdy;
    } vec_t;

    vec_t tv[$];

    dds_phase_acc #(
        .ACC_W(32),
        .OUT_W(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ftw     (cfg_ftw),
        .cfg_poff    (cfg_poff),
        .cfg_step    (cfg_step),
        .cfg_sync    (cfg_sync),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap_pulse  (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void r(bit rs, bit e, bit v, bit sy, logic [31:0] f, logic [31:0] p,
                              logic [31:0] s, logic [15:0] ph, bit pv, bit wr, bit rdy);
        vec_t x;
        x.rst      = rs;
        x.en       = e;
        x.vld      = v;
        x.cfg.ftw  = f;
        x.cfg.poff = p;
        x.cfg.step = s;
        x.cfg.sync = sy;
        x.e_phase  = ph;
        x.e_pv     = pv;
        x.e_wrap   = wr;
        x.e_rdy    = rdy;
        tv.push_back(x);
    endfunction

    function automatic void idle(logic [15:0] ph, bit pv, bit wr, bit rdy);
        r(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, ph, pv, wr, rdy);
    endfunction

    function automatic void rst_rows();
        r(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0, 0, 0, 0);
        r(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0, 0, 0, 0);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ftw   = '0;
        cfg_poff  = '0;
        cfg_step  = '0;
        cfg_sync  = 1'b0;

        // Reset, then immediate config ftw=0x4000_0000 and a full turn.
        rst_rows();
        r(0, 1, 1, 0, 32'h4000_0000, 32'h0, 32'h0, 16'h0000, 1, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        idle(16'h4000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        idle(16'hC000, 1, 0, 1);
        idle(16'h0000, 1, 1, 1);
        // Wrap-synchronised retune; second request while pending must be ignored.
        r(0, 1, 1, 1, 32'h2000_0000, 32'h0, 32'h0, 16'h4000, 1, 0, 0);
        r(0, 1, 1, 0, 32'h1111_0000, 32'h0, 32'h0, 16'h8000, 1, 0, 0);
        idle(16'hC000, 1, 0, 1);
        idle(16'h0000, 1, 1, 1);
        idle(16'h2000, 1, 0, 1);
        idle(16'h4000, 1, 0, 1);
        // Enable dropped for three cycles.
        r(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h4000, 0, 0, 1);
        r(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h4000, 0, 0, 1);
        r(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h4000, 0, 0, 1);
        idle(16'h6000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        // Linear sweep from ftw=0.
        rst_rows();
        r(0, 1, 1, 0, 32'h0, 32'h0, 32'h0100_0000, 16'h0000, 1, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0100, 1, 0, 1);
        idle(16'h0300, 1, 0, 1);
        idle(16'h0600, 1, 0, 1);
        // Constant phase via offset only.
        rst_rows();
        r(0, 1, 1, 0, 32'h0, 32'h8000_0000, 32'h0, 16'h0000, 1, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        idle(16'h8000, 1, 0, 1);
        // Reset while a wrap-synchronised config is pending.
        rst_rows();
        r(0, 1, 1, 0, 32'h4000_0000, 32'h0, 32'h0, 16'h0000, 1, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        r(0, 1, 1, 1, 32'h1000_0000, 32'h0, 32'h0, 16'h4000, 1, 0, 0);
        idle(16'h8000, 1, 0, 0);
        r(1, 1, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0000, 0, 0, 0);
        r(0, 1, 1, 0, 32'h0800_0000, 32'h0, 32'h0, 16'h0000, 1, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0800, 1, 0, 1);
        idle(16'h1000, 1, 0, 1);
        // Immediate config accepted with en low waits for the next enabled edge.
        rst_rows();
        r(0, 0, 1, 0, 32'h4000_0000, 32'h0, 32'h0, 16'h0000, 0, 0, 0);
        r(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0000, 0, 0, 0);
        r(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0000, 0, 0, 0);
        idle(16'h0000, 1, 0, 1);
        idle(16'h0000, 1, 0, 1);
        idle(16'h4000, 1, 0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst       = tv[i].rst;
            en        = tv[i].en;
            cfg_valid = tv[i].vld;
            cfg_ftw   = tv[i].cfg.ftw;
            cfg_poff  = tv[i].cfg.poff;
            cfg_step  = tv[i].cfg.step;
            cfg_sync  = tv[i].cfg.sync;
            if (i > 0 && tv[i-1].rst && !tv[i].rst) begin
                #1;
                chk("ready_after_rst", i, {31'b0, cfg_ready}, 32'd1);
            end
            @(posedge clk);
            #1;
            chk("phase_out",   i, {16'b0, phase_out},   {16'b0, tv[i].e_phase});
            chk("phase_valid", i, {31'b0, phase_valid}, {31'b0, tv[i].e_pv});
            chk("wrap_pulse",  i, {31'b0, wrap_pulse},  {31'b0, tv[i].e_wrap});
            chk("cfg_ready",   i, {31'b0, cfg_ready},   {31'b0, tv[i].e_rdy});
            $display("step %0d rst=%0b en=%0b vld=%0b phase=0x%04h pv=%0b wrap=%0b rdy=%0b",
                     i, tv[i].rst, tv[i].en, tv[i].vld, phase_out, phase_valid, wrap_pulse, cfg_ready);
        end

        // Wrap-synchronised config with ftw=0, step=0 never applies.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_ftw   = 32'h4000_0000;
        cfg_poff  = 32'h0;
        cfg_step  = 32'h0;
        cfg_sync  = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_accept_ready", 0, {31'b0, cfg_ready}, 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", k, {31'b0, cfg_ready}, 32'd0);
            chk("stall_phase", k, {16'b0, phase_out}, 32'd0);
            chk("stall_wrap",  k, {31'b0, wrap_pulse}, 32'd0);
        end
        $display("stall sequence: 20 enabled cycles, rdy=%0b phase=0x%04h", cfg_ready, phase_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
